// File: rtl/payload_rr_arbiter_pkg.sv
// Shared payload definitions and the round-robin search helper used by the
// request-side arbiter and future response-side demux arbiters.
package payload_rr_arbiter_pkg;

  localparam int unsigned ID_WIDTH   = 3;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned MAX_SRC    = 2 ** ID_WIDTH;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } payload_t;

  typedef struct packed {
    logic                found;
    logic [ID_WIDTH-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping past num_src-1 to 0.
  function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0]  valid,
                                       input logic [ID_WIDTH-1:0] ptr,
                                       input int unsigned         num_src);
    rr_pick_t    res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      if (i < num_src) begin
        j = 32'(ptr) + i;
        if (j >= num_src) j = j - num_src;
        if (!res.found && valid[j[ID_WIDTH-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[ID_WIDTH-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/payload_rr_arbiter_if.sv
// Source-side request channels plus the merged, registered output stream.
interface payload_rr_arbiter_if
  import payload_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) ();

  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  payload_t                      out_payload;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output src_valid, src_addr, src_data, out_ready,
    input  src_ready, out_payload, out_valid
  );

  modport slave (
    input  src_valid, src_addr, src_data, out_ready,
    output src_ready, out_payload, out_valid
  );

endinterface

// File: rtl/payload_rr_arbiter_pick.sv
// Purely combinational round-robin winner search over NUM_SRC requests.
module rr_pick_comb
  import payload_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned SrcW   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid_i,
  input  logic [SrcW-1:0]    ptr_i,
  output logic               found_o,
  output logic [SrcW-1:0]    idx_o
);

  rr_pick_t res;

  always_comb begin
    res     = rr_pick(MAX_SRC'(valid_i), ID_WIDTH'(ptr_i), NUM_SRC);
    found_o = res.found;
    idx_o   = SrcW'(res.idx);
  end

endmodule

// File: rtl/payload_rr_arbiter.sv
// Round-robin merge of NUM_SRC valid/ready channels into one registered payload stream
// tagged with the originating source index.
module payload_rr_arbiter
  import payload_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  payload_rr_arbiter_if.slave  bus,
  output logic [15:0]          grant_cnt
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  payload_t         payload_q;
  logic             valid_q;
  logic [15:0]      cnt_q;

  logic             found;
  logic [SRC_W-1:0] win;
  logic             free;
  logic             accept;

  rr_pick_comb #(
    .NUM_SRC(NUM_SRC)
  ) u_pick (
    .valid_i(bus.src_valid),
    .ptr_i  (ptr_q),
    .found_o(found),
    .idx_o  (win)
  );

  always_comb begin
    free   = (state_q == StEmpty) || bus.out_ready;
    accept = free && found;
    ptr_d  = (32'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;
    bus.src_ready = '0;
    // Reset masks ready so no source believes a beat was taken and then dropped.
    if (!rst && accept) bus.src_ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      ptr_q     <= '0;
      payload_q <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      payload_q <= '{id:   ID_WIDTH'(win),
                     addr: bus.src_addr[win*ADDR_WIDTH +: ADDR_WIDTH],
                     data: bus.src_data[win*DATA_WIDTH +: DATA_WIDTH]};
      valid_q   <= 1'b1;
      state_q   <= StFull;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_q + 16'd1;
    end else if (state_q == StFull && bus.out_ready) begin
      valid_q   <= 1'b0;
      state_q   <= StEmpty;
    end
  end

  assign bus.out_payload = payload_q;
  assign bus.out_valid   = valid_q;
  assign grant_cnt       = cnt_q;

endmodule

// File: tb/tb_payload_rr_arbiter.sv
// Directed bench: a 4-source instance for protocol behaviour and a 3-source
// instance for non-power-of-two wrap and grant counter rollover.
module tb_payload_rr_arbiter;
  import payload_rr_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst4, rst3;
  logic [15:0] cnt4, cnt3;
  int          total = 0;
  int          bad = 0;
  int          errs;
  payload_t    exp_p;

  always #5 clk = ~clk;

  payload_rr_arbiter_if #(.NUM_SRC(4)) s4 ();
  payload_rr_arbiter_if #(.NUM_SRC(3)) s3 ();

  payload_rr_arbiter #(.NUM_SRC(4)) u4 (.clk(clk), .rst(rst4), .bus(s4), .grant_cnt(cnt4));
  payload_rr_arbiter #(.NUM_SRC(3)) u3 (.clk(clk), .rst(rst3), .bus(s3), .grant_cnt(cnt3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    s4.src_valid = 4'b1111;
    s4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s4.src_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = 16'(32'h100 * i);
      s4.src_data[i*DATA_WIDTH +: DATA_WIDTH] = 32'h1000 + 32'(i);
    end
    s3.src_valid = '0;
    s3.out_ready = 1'b1;
    s3.src_addr  = '0;
    s3.src_data  = '0;

    // Reset with all sources requesting
    #1;
    check("rst_ready_pre", 64'(s4.src_ready), 64'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready", 64'(s4.src_ready), 64'h0);
      check("rst_valid", 64'(s4.out_valid), 64'h0);
      check("rst_payload", 64'(s4.out_payload), 64'h0);
      check("rst_cnt", 64'(cnt4), 64'h0);
    end
    rst4 = 1'b0;
    #1;

    // Round-robin with all valid, first grant to source 0
    for (int k = 0; k < 8; k++) begin
      check("rr_ready", 64'(s4.src_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check("rr_valid", 64'(s4.out_valid), 64'h1);
      check("rr_id", 64'(s4.out_payload.id), 64'(k % 4));
      check("rr_addr", 64'(s4.out_payload.addr), 64'(32'h100 * (k % 4)));
    end
    check("rr_cnt", 64'(cnt4), 64'd8);

    // Backpressure: load source 2, then stall with everyone requesting
    s4.src_valid = 4'b0100;
    s4.src_addr[2*ADDR_WIDTH +: ADDR_WIDTH] = 16'h00A0;
    s4.src_data[2*DATA_WIDTH +: DATA_WIDTH] = 32'h0000_DEAD;
    #1;
    check("bp_fill_ready", 64'(s4.src_ready), 64'b0100);
    tick();
    exp_p = '{id: 3'd2, addr: 16'h00A0, data: 32'h0000_DEAD};
    s4.out_ready = 1'b0;
    s4.src_valid = 4'b1111;
    s4.src_addr[2*ADDR_WIDTH +: ADDR_WIDTH] = 16'h0055;
    #1;
    check("bp_ready0", 64'(s4.src_ready), 64'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_payload", 64'(s4.out_payload), 64'(exp_p));
      check("bp_valid", 64'(s4.out_valid), 64'h1);
      check("bp_ready", 64'(s4.src_ready), 64'h0);
    end
    s4.out_ready = 1'b1;
    s4.src_valid = 4'b0000;
    tick();
    check("bp_drain", 64'(s4.out_valid), 64'h0);
    check("bp_cnt", 64'(cnt4), 64'd9);

    // Sparse: pointer is 3 here; grant source 1 to move it to 2
    s4.src_valid = 4'b0010;
    #1;
    check("sp_pre_ready", 64'(s4.src_ready), 64'b0010);
    tick();
    s4.src_valid = 4'b1010;
    #1;
    check("sp_ready0", 64'(s4.src_ready), 64'b1000);
    tick();
    check("sp_id0", 64'(s4.out_payload.id), 64'd3);
    check("sp_ready1", 64'(s4.src_ready), 64'b0010);
    tick();
    check("sp_id1", 64'(s4.out_payload.id), 64'd1);
    check("sp_ready2", 64'(s4.src_ready), 64'b1000);
    tick();
    check("sp_id2", 64'(s4.out_payload.id), 64'd3);
    check("sp_ready3", 64'(s4.src_ready), 64'b0010);
    tick();
    check("sp_id3", 64'(s4.out_payload.id), 64'd1);
    check("sp_cnt", 64'(cnt4), 64'd14);

    // Drain to empty: single beat from source 0
    s4.src_valid = 4'b0001;
    #1;
    check("de_ready", 64'(s4.src_ready), 64'b0001);
    tick();
    s4.src_valid = 4'b0000;
    check("de_valid1", 64'(s4.out_valid), 64'h1);
    check("de_id", 64'(s4.out_payload.id), 64'd0);
    tick();
    check("de_valid2", 64'(s4.out_valid), 64'h0);
    tick();
    check("de_valid3", 64'(s4.out_valid), 64'h0);
    // Empty slot accepts even with out_ready low; pointer should be at 1
    s4.out_ready = 1'b0;
    s4.src_valid = 4'b1111;
    #1;
    check("de_ptr", 64'(s4.src_ready), 64'b0010);
    tick();
    check("de_id_next", 64'(s4.out_payload.id), 64'd1);
    check("de_cnt", 64'(cnt4), 64'd16);

    // Reset while holding a stalled beat
    rst4 = 1'b1;
    #1;
    check("mr_ready", 64'(s4.src_ready), 64'h0);
    tick();
    check("mr_valid", 64'(s4.out_valid), 64'h0);
    check("mr_payload", 64'(s4.out_payload), 64'h0);
    check("mr_cnt", 64'(cnt4), 64'h0);
    rst4 = 1'b0;

    // Three sources: ID pattern 0,1,2 and counter wrap after 65537 beats
    s3.src_valid = 3'b111;
    tick();
    tick();
    rst3 = 1'b0;
    errs = 0;
    for (int k = 0; k < 65537; k++) begin
      tick();
      if (s3.out_payload.id !== 3'(k % 3) || s3.out_valid !== 1'b1) errs++;
    end
    check("w3_ids", 64'(errs), 64'h0);
    check("w3_cnt", 64'(cnt3), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/payload_rr_arbiter.md
Name: payload_rr_arbiter

Overview:
- Upstream neighbour of the payload register-slice FIFO.
- Merges NUM_SRC independent valid/ready request channels into one payload_t stream using round-robin arbitration.
- The granted source index is written into payload_t.ID, so downstream stages can route responses back to the originator.
- Output is registered, so it drives the slice's in_payload/svalid directly with no combinational path from the source inputs.

Parameters:
- NUM_SRC, 4, number of request sources; legal range 2..2**ID_WIDTH (2..8).
- SRC_W, $clog2(NUM_SRC), width of the grant index and RR pointer (internal localparam).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- src_valid  input  NUM_SRC  per-source request valid.
- src_addr  input  NUM_SRC*ADDR_WIDTH  per-source address, source i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- src_data  input  NUM_SRC*DATA_WIDTH  per-source data, same packing as src_addr.
- src_ready  output  NUM_SRC  per-source accept; one-hot or zero.
- out_payload  output  $bits(payload_t)  registered merged payload {ID, ADDR, DATA}.
- out_valid  output  1  out_payload holds a beat.
- out_ready  input  1  downstream accepts; connects to the slice's sready.
- grant_cnt  output  16  count of accepted source beats, wraps at 65535 -> 0.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - out_valid=0, out_payload=0, RR pointer=0, grant_cnt=0, state=EMPTY.
  - src_ready is forced to 0 while rst=1.
- States:
  - EMPTY: output register holds nothing; out_valid=0.
  - FULL: out_valid=1.
- Slot free: free = (state==EMPTY) || out_ready.
- Arbitration, evaluated combinationally each cycle:
  - Search src_valid starting at index ptr, ascending with wrap past NUM_SRC-1 to 0; the first set bit is the winner w.
  - src_ready[w] = free. All other src_ready bits = 0.
  - src_ready depends on src_valid and out_ready only. It must not depend on itself.
- Accept: when free && any src_valid, at the clock edge:
  - out_payload <= {w, src_addr[w], src_data[w]}.
  - out_valid <= 1; state -> FULL.
  - ptr <= (w+1) mod NUM_SRC.
  - grant_cnt <= grant_cnt+1.
- Drain: when state==FULL && out_ready && no src_valid, at the edge: out_valid <= 0, state -> EMPTY. ptr is unchanged.
- Stall: when state==FULL && !out_ready:
  - out_payload and out_valid hold stable (AXI-style stability).
  - All src_ready bits are 0.
- Simultaneous drain and accept (FULL, out_ready=1, some src_valid=1): back-to-back transfer with no bubble. Sustained throughput is 1 beat/cycle.
- Latency: a source beat accepted at edge N is visible on out_payload/out_valid right after edge N (1 cycle).
- Fairness: with all sources continuously valid, grants follow 0,1,...,NUM_SRC-1,0,... A source waits at most NUM_SRC-1 accepted beats.
- Non-power-of-two NUM_SRC: ptr wraps from NUM_SRC-1 to 0. Index values >= NUM_SRC never appear in ID.
- ID field: the grant index is zero-extended to ID_WIDTH.
- Reset mid-transfer: a pending out beat is discarded. Sources see src_ready=0 during the reset cycle, so no beat is lost silently from their side.
- src_valid dropping while not granted is tolerated and is not flagged.

Decomposition:
- Use the existing payload_package (ID_WIDTH, ADDR_WIDTH, DATA_WIDTH, payload_t).
- Add to payload_package:
  - localparam MAX_SRC = 2**ID_WIDTH.
  - A function rr_pick(valid, ptr) returning the winner index plus a found flag.
- One natural sub-module: rr_pick_comb. It is a purely combinational rotate / priority-encode / un-rotate, parameterised by NUM_SRC, and is reused by future response-side demux arbiters.
- Top level holds the output register, the EMPTY/FULL state, ptr and grant_cnt.

Test Plan:
- Reset: assert rst for 2 cycles with all src_valid=1 -> src_ready=0, out_valid=0, out_payload=0, grant_cnt=0 throughout. The first grant after release goes to source 0.
- Round-robin: NUM_SRC=4, all valid, out_ready=1, addr_i=0x100*i -> over 8 cycles out ID sequence is 0,1,2,3,0,1,2,3 and out_valid is 1 every cycle. grant_cnt=8.
- Backpressure: fill with source 2 (ADDR=0xA0, DATA=0xDEAD), then hold out_ready=0 for 5 cycles -> out_payload={2,0xA0,0xDEAD} stable and all src_ready=0. On release it drains in 1 cycle.
- Sparse/skip: only sources 1 and 3 valid, ptr=2 -> grants 3,1,3,1. ptr after each grant is 0,2,0,2.
- Drain to empty: single beat from source 0 with out_ready=1 and no further valid -> out_valid high for exactly 1 cycle, then 0. ptr stays 1.
- Non-power-of-two and wrap: NUM_SRC=3, all valid, 65537 accepted beats -> IDs cycle 0,1,2 (never 3) and grant_cnt=1 after wrap.
